// File: rtl/timer_match_ctrl.sv
// Compare engine for a free-running up-counter: edge-qualified match pulse, sticky irq,
// saturating match counter, wrap-synchronised compare reload. Option: TIMER_MATCH_WRAP_IRQ_EN.
module timer_match_ctrl #(
  parameter int WIDTH  = 17,
  parameter int MCNT_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              enable,
  input  logic              periodic,
  input  logic              cmp_wr,
  input  logic [WIDTH-1:0]  cmp_data,
  input  logic              irq_ack,
  output logic              match_pulse,
  output logic              irq,
  output logic              armed,
  output logic [MCNT_W-1:0] match_count,
`ifdef TIMER_MATCH_WRAP_IRQ_EN
  output logic              wrap_flag,
`endif
  output logic [WIDTH-1:0]  cmp_active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_mode_q;
  logic              r_armed;
  logic [WIDTH-1:0]  r_cnt_q;
  logic [WIDTH-1:0]  r_cnt_prev;
  logic [WIDTH-1:0]  r_cmp_shadow;
  logic [WIDTH-1:0]  r_cmp_active;
  logic              r_shadow_pend;
  logic              r_eq_prev;
  logic              r_match_pulse;
  logic              r_irq;
  logic [MCNT_W-1:0] r_match_count;

  logic w_eq;
  logic w_wrap;
  logic w_match;
  logic w_xfer;
  logic w_wrap_set;
  logic w_irq_set;

  function automatic logic [MCNT_W-1:0] sat_inc(input logic [MCNT_W-1:0] v);
    if (v == {MCNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(MCNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Any count decrease is a wrap, so an upstream clear also releases a pending compare value.
  always_comb begin
    w_eq       = (r_cnt_q == r_cmp_active);
    w_wrap     = (r_cnt_q < r_cnt_prev);
    w_match    = w_eq & ~r_eq_prev & (r_state == ST_ARMED);
    w_xfer     = r_shadow_pend & w_wrap & (r_state != ST_IDLE);
    w_wrap_set = w_wrap & (r_state != ST_IDLE);
`ifdef TIMER_MATCH_WRAP_IRQ_EN
    w_irq_set  = w_match | w_wrap_set;
`else
    w_irq_set  = w_match;
`endif
  end

  // Input pipeline and edge history for the match qualifier.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt_q    <= {WIDTH{1'b0}};
      r_cnt_prev <= {WIDTH{1'b0}};
      r_eq_prev  <= 1'b0;
    end else begin
      r_cnt_q    <= cnt_in;
      r_cnt_prev <= r_cnt_q;
      r_eq_prev  <= w_eq;
    end
  end

  // Compare double buffer; a write landing on a wrap cycle stays pending behind the older value.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cmp_shadow  <= {WIDTH{1'b0}};
      r_cmp_active  <= {WIDTH{1'b0}};
      r_shadow_pend <= 1'b0;
    end else if (cmp_wr && (r_state == ST_IDLE)) begin
      r_cmp_shadow  <= cmp_data;
      r_cmp_active  <= cmp_data;
      r_shadow_pend <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_cmp_active <= r_cmp_shadow;
      end else begin
        r_cmp_active <= r_cmp_active;
      end
      if (cmp_wr) begin
        r_cmp_shadow  <= cmp_data;
        r_shadow_pend <= 1'b1;
      end else if (w_xfer) begin
        r_shadow_pend <= 1'b0;
      end else begin
        r_shadow_pend <= r_shadow_pend;
      end
    end
  end

  // Control FSM with registered armed flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= ST_IDLE;
      r_mode_q <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state  <= ST_ARMED;
            r_mode_q <= periodic;
            r_armed  <= 1'b1;
          end else begin
            r_armed  <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
          end else if (w_match && !r_mode_q) begin
            r_state <= ST_DONE;
            r_armed <= 1'b0;
          end else begin
            r_armed <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
          end else if (w_xfer) begin
            r_state <= ST_ARMED;
            r_armed <= 1'b1;
          end else begin
            r_armed <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  // Match pulse, saturating event count and sticky irq (set beats ack).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_match_pulse <= 1'b0;
      r_match_count <= {MCNT_W{1'b0}};
      r_irq         <= 1'b0;
    end else begin
      r_match_pulse <= w_match;
      if (w_match) begin
        r_match_count <= sat_inc(r_match_count);
      end else begin
        r_match_count <= r_match_count;
      end
      if (w_irq_set) begin
        r_irq <= 1'b1;
      end else if (irq_ack) begin
        r_irq <= 1'b0;
      end else begin
        r_irq <= r_irq;
      end
    end
  end

`ifdef TIMER_MATCH_WRAP_IRQ_EN
  logic r_wrap_flag;

  // Wrap status flag, cleared together with irq.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_wrap_flag <= 1'b0;
    end else if (w_wrap_set) begin
      r_wrap_flag <= 1'b1;
    end else if (irq_ack) begin
      r_wrap_flag <= 1'b0;
    end else begin
      r_wrap_flag <= r_wrap_flag;
    end
  end

  assign wrap_flag = r_wrap_flag;
`endif

  assign match_pulse = r_match_pulse;
  assign irq         = r_irq;
  assign armed       = r_armed;
  assign match_count = r_match_count;
  assign cmp_active  = r_cmp_active;

endmodule

// File: tb/tb_timer_match_ctrl.sv
// Directed bench for timer_match_ctrl: a default-width instance and an MCNT_W=2 instance share stimulus.
module tb_timer_match_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [16:0] cnt_in;
  logic        enable;
  logic        periodic;
  logic        cmp_wr;
  logic [16:0] cmp_data;
  logic        irq_ack;
  logic        match_pulse, irq, armed;
  logic [7:0]  match_count;
  logic [16:0] cmp_active;
  logic        match_pulse2, irq2, armed2;
  logic [1:0]  match_count2;
  logic [16:0] cmp_active2;
`ifdef TIMER_MATCH_WRAP_IRQ_EN
  logic        wrap_flag, wrap_flag2;
`endif

  int nvec  = 0;
  int nfail = 0;
  logic [16:0] h1 = 17'd0;
  logic [16:0] h2 = 17'd0;

  always #5 clk = ~clk;

  timer_match_ctrl #(.WIDTH(17), .MCNT_W(8)) dut (
    .clk(clk), .clr(clr), .cnt_in(cnt_in), .enable(enable), .periodic(periodic),
    .cmp_wr(cmp_wr), .cmp_data(cmp_data), .irq_ack(irq_ack),
    .match_pulse(match_pulse), .irq(irq), .armed(armed), .match_count(match_count),
`ifdef TIMER_MATCH_WRAP_IRQ_EN
    .wrap_flag(wrap_flag),
`endif
    .cmp_active(cmp_active)
  );

  timer_match_ctrl #(.WIDTH(17), .MCNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .cnt_in(cnt_in), .enable(enable), .periodic(periodic),
    .cmp_wr(cmp_wr), .cmp_data(cmp_data), .irq_ack(irq_ack),
    .match_pulse(match_pulse2), .irq(irq2), .armed(armed2), .match_count(match_count2),
`ifdef TIMER_MATCH_WRAP_IRQ_EN
    .wrap_flag(wrap_flag2),
`endif
    .cmp_active(cmp_active2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one count value; the pulse seen now belongs to the value driven one step earlier.
  task automatic step(input logic [16:0] v, input logic [16:0] c, input logic en);
    logic exp_p;
    exp_p = en && (h1 == c) && (h2 != c);
    h2 = h1;
    h1 = v;
    cnt_in = v;
    tick();
    chk("match_pulse", {31'd0, match_pulse}, {31'd0, exp_p});
  endtask

  task automatic ramp(input logic [16:0] lo, input logic [16:0] hi, input logic [16:0] c,
                      input logic en);
    for (logic [17:0] v = {1'b0, lo}; v <= {1'b0, hi}; v++) begin
      step(v[16:0], c, en);
    end
  endtask

  initial begin
    clr = 1'b0; cnt_in = 17'd0; enable = 1'b0; periodic = 1'b0;
    cmp_wr = 1'b0; cmp_data = 17'd0; irq_ack = 1'b0;
    tick(); tick();
    chk("rst_pulse", {31'd0, match_pulse}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd0);
    chk("rst_count", {24'd0, match_count}, 32'd0);
    chk("rst_cmp", {15'd0, cmp_active}, 32'd0);
    clr = 1'b1;
    tick();

    // Three matches, then an asynchronous reset between edges.
    cmp_wr = 1'b1; cmp_data = 17'd10; tick(); cmp_wr = 1'b0;
    chk("idle_wr_cmp", {15'd0, cmp_active}, 32'd10);
    enable = 1'b1; periodic = 1'b1; tick();
    chk("armed_on", {31'd0, armed}, 32'd1);
    for (int p = 0; p < 3; p++) begin
      ramp(17'd8, 17'd12, 17'd10, 1'b1);
      if (p < 2) step(17'd0, 17'd10, 1'b1);
    end
    chk("pre_rst_count", {24'd0, match_count}, 32'd3);
    chk("pre_rst_count2", {30'd0, match_count2}, 32'd3);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("arst_pulse", {31'd0, match_pulse}, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_armed", {31'd0, armed}, 32'd0);
    chk("arst_count", {24'd0, match_count}, 32'd0);
    chk("arst_count2", {30'd0, match_count2}, 32'd0);
    chk("arst_cmp", {15'd0, cmp_active}, 32'd0);
`ifdef TIMER_MATCH_WRAP_IRQ_EN
    chk("arst_wrap_flag", {31'd0, wrap_flag}, 32'd0);
`endif
    tick(); tick();
    enable = 1'b0;
    clr = 1'b1;
    tick();
    chk("post_rst_armed", {31'd0, armed}, 32'd0);
    tick();
    chk("post_rst_idle", {31'd0, armed}, 32'd0);

    // Periodic mode, compare 100, two wraps.
    cmp_wr = 1'b1; cmp_data = 17'd100; tick(); cmp_wr = 1'b0;
    chk("idle_wr_100", {15'd0, cmp_active}, 32'd100);
    enable = 1'b1; periodic = 1'b1; tick();
    chk("per_armed", {31'd0, armed}, 32'd1);
    ramp(17'd95, 17'd105, 17'd100, 1'b1);
    ramp(17'h1FFFD, 17'h1FFFF, 17'd100, 1'b1);
    ramp(17'd0, 17'd105, 17'd100, 1'b1);
    chk("per_count", {24'd0, match_count}, 32'd2);
    chk("per_count2", {30'd0, match_count2}, 32'd2);
    chk("per_irq", {31'd0, irq}, 32'd1);
    chk("per_armed2", {31'd0, armed}, 32'd1);
    ramp(17'h1FFFE, 17'h1FFFF, 17'd100, 1'b1);

    // Ack collides with a new match: set wins; a lone ack clears.
    ramp(17'd0, 17'd100, 17'd100, 1'b1);
    irq_ack = 1'b1;
    step(17'd101, 17'd100, 1'b1);
    irq_ack = 1'b0;
    chk("coll_irq", {31'd0, irq}, 32'd1);
    chk("coll_count", {24'd0, match_count}, 32'd3);
    chk("sat_count2_a", {30'd0, match_count2}, 32'd3);
    step(17'd102, 17'd100, 1'b1);
    chk("coll_irq_hold", {31'd0, irq}, 32'd1);
    irq_ack = 1'b1;
    step(17'd103, 17'd100, 1'b1);
    irq_ack = 1'b0;
    chk("ack_clears", {31'd0, irq}, 32'd0);

    // Compare written while armed waits for wrap; then a stalled counter.
    cmp_wr = 1'b1; cmp_data = 17'd200;
    step(17'd104, 17'd100, 1'b1);
    cmp_wr = 1'b0;
    chk("shadow_hold", {15'd0, cmp_active}, 32'd100);
    ramp(17'd105, 17'd110, 17'd200, 1'b0);
    ramp(17'd195, 17'd205, 17'd200, 1'b0);
    step(17'h1FFFF, 17'd200, 1'b0);
    step(17'd0, 17'd200, 1'b0);
    chk("xfer_not_yet", {15'd0, cmp_active}, 32'd100);
    step(17'd1, 17'd200, 1'b0);
    chk("xfer_at_wrap", {15'd0, cmp_active}, 32'd200);
    ramp(17'd195, 17'd199, 17'd200, 1'b1);
    for (int i = 0; i < 10; i++) step(17'd200, 17'd200, 1'b1);
    step(17'd201, 17'd200, 1'b1);
    chk("stall_count", {24'd0, match_count}, 32'd4);
    chk("sat_count2_b", {30'd0, match_count2}, 32'd3);

    // Leave ARMED keeping irq; one-shot with re-arm on wrap.
    enable = 1'b0;
    step(17'd202, 17'd200, 1'b0);
    chk("idle_armed", {31'd0, armed}, 32'd0);
    chk("idle_irq_kept", {31'd0, irq}, 32'd1);
    cmp_wr = 1'b1; cmp_data = 17'd50;
    step(17'd203, 17'd50, 1'b0);
    cmp_wr = 1'b0;
    chk("idle_wr_50", {15'd0, cmp_active}, 32'd50);
    enable = 1'b1; periodic = 1'b0;
    step(17'd204, 17'd50, 1'b0);
    chk("os_armed", {31'd0, armed}, 32'd1);
    ramp(17'd45, 17'd55, 17'd50, 1'b1);
    chk("os_done", {31'd0, armed}, 32'd0);
    chk("os_count", {24'd0, match_count}, 32'd5);
    ramp(17'h1FFFE, 17'h1FFFF, 17'd50, 1'b0);
    ramp(17'd0, 17'd55, 17'd50, 1'b0);
    chk("done_hold", {31'd0, armed}, 32'd0);
    chk("done_count", {24'd0, match_count}, 32'd5);
    cmp_wr = 1'b1; cmp_data = 17'd70;
    step(17'd56, 17'd70, 1'b0);
    cmp_wr = 1'b0;
    chk("done_shadow", {15'd0, cmp_active}, 32'd50);
    step(17'h1FFFF, 17'd70, 1'b0);
    step(17'd0, 17'd70, 1'b0);
    chk("rearm_wait", {31'd0, armed}, 32'd0);
    step(17'd1, 17'd70, 1'b0);
    chk("rearm_cmp", {15'd0, cmp_active}, 32'd70);
    chk("rearm_armed", {31'd0, armed}, 32'd1);
    ramp(17'd2, 17'd75, 17'd70, 1'b1);
    chk("rearm_done", {31'd0, armed}, 32'd0);
    chk("final_count", {24'd0, match_count}, 32'd6);
    chk("sat_count2_c", {30'd0, match_count2}, 32'd3);

    // Wrap in DONE: wrap_flag/irq when enabled, irq untouched otherwise.
    irq_ack = 1'b1;
    step(17'd76, 17'd70, 1'b0);
    irq_ack = 1'b0;
    chk("ack2_irq", {31'd0, irq}, 32'd0);
    step(17'h1FFFF, 17'd70, 1'b0);
    step(17'd0, 17'd70, 1'b0);
    step(17'd1, 17'd70, 1'b0);
`ifdef TIMER_MATCH_WRAP_IRQ_EN
    chk("wrap_flag_set", {31'd0, wrap_flag}, 32'd1);
    chk("wrap_irq_set", {31'd0, irq}, 32'd1);
    irq_ack = 1'b1;
    step(17'd2, 17'd70, 1'b0);
    irq_ack = 1'b0;
    chk("wrap_flag_ack", {31'd0, wrap_flag}, 32'd0);
    chk("wrap_irq_ack", {31'd0, irq}, 32'd0);
`else
    chk("wrap_no_irq", {31'd0, irq}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
